// File: rtl/arbiter_router_router.sv
// Return-path router: strips the {addr, data} header and steers the payload to
// the destination stream selected by addr, through a 2-entry in-order FIFO.
module arbiter_router_router #(
   parameter int nbits      = 32,
   parameter int noutputs   = 3,
   parameter int addr_nbits = $clog2(noutputs)
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic                        istream_val,
   output logic                        istream_rdy,
   input  logic [addr_nbits+nbits-1:0] istream_msg,
   output logic                        ostream_val [noutputs],
   input  logic                        ostream_rdy [noutputs],
   output logic [nbits-1:0]            ostream_msg [noutputs],
   output logic [15:0]                 drop_count
);

   localparam int W = addr_nbits + nbits;

   logic [W-1:0]          mem_q [2];
   logic                  wptr_q, rptr_q;
   logic [1:0]            count_q, count_d;
   logic                  live_q;
   logic [15:0]           drop_q, drop_d;

   logic [W-1:0]          head;
   logic [addr_nbits-1:0] head_addr;
   logic                  addr_ok, nonempty, sel_rdy;
   logic                  push, pop, drop;

   // live_q keeps istream_rdy low while in reset and until the first edge after release
   assign istream_rdy = live_q && (count_q != 2'd2);
   assign push        = istream_val && istream_rdy;
   assign drop_count  = drop_q;

   always_comb begin
      head      = mem_q[rptr_q];
      head_addr = head[W-1:nbits];
      addr_ok   = (int'(head_addr) < noutputs);
      nonempty  = (count_q != 2'd0);
      sel_rdy   = 1'b0;
      for (int unsigned i = 0; i < noutputs; i++) begin
         ostream_val[i] = nonempty && addr_ok && (head_addr == addr_nbits'(i));
         ostream_msg[i] = nonempty ? head[nbits-1:0] : '0;
         if (head_addr == addr_nbits'(i)) sel_rdy = ostream_rdy[i];
      end
      pop  = nonempty && (!addr_ok || sel_rdy);
      drop = nonempty && !addr_ok;

      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase

      drop_d = drop_q;
      if (drop && (drop_q != '1)) drop_d = drop_q + 16'd1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wptr_q  <= 1'b0;
         rptr_q  <= 1'b0;
         count_q <= '0;
         live_q  <= 1'b0;
         drop_q  <= '0;
      end else begin
         live_q  <= 1'b1;
         count_q <= count_d;
         drop_q  <= drop_d;
         if (push) wptr_q <= ~wptr_q;
         if (pop)  rptr_q <= ~rptr_q;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wptr_q] <= istream_msg;
   end

endmodule

// File: tb/tb_arbiter_router_router.sv
// Directed bench for arbiter_router_router with nbits=8, noutputs=3.
module tb_arbiter_router_router;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       ival = 1'b0;
   logic       irdy;
   logic [9:0] imsg = '0;
   logic       oval [3];
   logic       ordy [3];
   logic [7:0] omsg [3];
   logic [15:0] drop;
   logic [2:0] ov;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   always_comb ov = {oval[2], oval[1], oval[0]};

   arbiter_router_router #(.nbits(8), .noutputs(3), .addr_nbits(2)) dut (
      .clk(clk), .reset_n(reset_n),
      .istream_val(ival), .istream_rdy(irdy), .istream_msg(imsg),
      .ostream_val(oval), .ostream_rdy(ordy), .ostream_msg(omsg),
      .drop_count(drop)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_rdy(input logic [2:0] r);
      ordy[0] = r[0];
      ordy[1] = r[1];
      ordy[2] = r[2];
   endtask

   task automatic test_reset();
      set_rdy(3'b111);
      #2;
      checks++; if (irdy !== 1'b0) begin failures++; $display("FAIL reset_irdy got=%b exp=0", irdy); end
      checks++; if (ov !== 3'b000) begin failures++; $display("FAIL reset_oval got=%b exp=000", ov); end
      checks++; if (drop !== 16'd0) begin failures++; $display("FAIL reset_drop got=%0d exp=0", drop); end
      tick();
      #2 reset_n = 1'b1;
      tick();
      checks++; if (irdy !== 1'b1) begin failures++; $display("FAIL release_irdy got=%b exp=1", irdy); end
      checks++; if (ov !== 3'b000) begin failures++; $display("FAIL release_oval got=%b exp=000", ov); end
   endtask

   task automatic test_single();
      set_rdy(3'b111);
      ival = 1'b1; imsg = {2'd1, 8'hA5};
      tick();
      ival = 1'b0;
      #1;
      checks++; if (ov !== 3'b010) begin failures++; $display("FAIL single_oval got=%b exp=010", ov); end
      checks++; if (omsg[1] !== 8'hA5) begin failures++; $display("FAIL single_msg1 got=%h exp=a5", omsg[1]); end
      checks++; if (omsg[0] !== 8'hA5) begin failures++; $display("FAIL single_msg0 got=%h exp=a5", omsg[0]); end
      tick();
      checks++; if (ov !== 3'b000) begin failures++; $display("FAIL single_after_pop got=%b exp=000", ov); end
   endtask

   task automatic test_full();
      set_rdy(3'b000);
      ival = 1'b1; imsg = {2'd0, 8'h11};
      tick();
      imsg = {2'd0, 8'h22};
      tick();
      imsg = {2'd0, 8'h33};
      #1;
      checks++; if (irdy !== 1'b0) begin failures++; $display("FAIL full_irdy got=%b exp=0", irdy); end
      checks++; if (ov !== 3'b001) begin failures++; $display("FAIL full_oval got=%b exp=001", ov); end
      checks++; if (omsg[0] !== 8'h11) begin failures++; $display("FAIL full_head got=%h exp=11", omsg[0]); end
      tick();
      checks++; if (omsg[0] !== 8'h11 || ov !== 3'b001) begin failures++; $display("FAIL full_stable got=%h/%b exp=11/001", omsg[0], ov); end
      set_rdy(3'b001);
      #1;
      checks++; if (irdy !== 1'b0) begin failures++; $display("FAIL full_no_comb_rdy got=%b exp=0", irdy); end
      tick();
      checks++; if (irdy !== 1'b1) begin failures++; $display("FAIL full_irdy_back got=%b exp=1", irdy); end
      checks++; if (omsg[0] !== 8'h22 || ov !== 3'b001) begin failures++; $display("FAIL full_second got=%h/%b exp=22/001", omsg[0], ov); end
      tick();
      ival = 1'b0;
      #1;
      checks++; if (omsg[0] !== 8'h33 || ov !== 3'b001) begin failures++; $display("FAIL full_third got=%h/%b exp=33/001", omsg[0], ov); end
      tick();
      checks++; if (ov !== 3'b000) begin failures++; $display("FAIL full_drained got=%b exp=000", ov); end
   endtask

   task automatic test_invalid();
      set_rdy(3'b111);
      ival = 1'b1; imsg = {2'd3, 8'h77};
      tick();
      imsg = {2'd2, 8'h44};
      #1;
      checks++; if (ov !== 3'b000) begin failures++; $display("FAIL inv_oval got=%b exp=000", ov); end
      checks++; if (drop !== 16'd0) begin failures++; $display("FAIL inv_drop0 got=%0d exp=0", drop); end
      tick();
      ival = 1'b0;
      #1;
      checks++; if (drop !== 16'd1) begin failures++; $display("FAIL inv_drop1 got=%0d exp=1", drop); end
      checks++; if (ov !== 3'b100 || omsg[2] !== 8'h44) begin failures++; $display("FAIL inv_next got=%b/%h exp=100/44", ov, omsg[2]); end
      tick();
      checks++; if (ov !== 3'b000) begin failures++; $display("FAIL inv_drained got=%b exp=000", ov); end
   endtask

   task automatic test_stream();
      logic [2:0] exp_ov;
      int unsigned a;
      set_rdy(3'b111);
      for (int unsigned k = 0; k < 12; k++) begin
         ival = 1'b1; imsg = {2'(k % 3), 8'(k)};
         #1;
         checks++; if (irdy !== 1'b1) begin failures++; $display("FAIL stream_irdy k=%0d got=%b exp=1", k, irdy); end
         if (k > 0) begin
            a = (k - 1) % 3;
            exp_ov = 3'b001 << a;
            checks++;
            if (ov !== exp_ov || omsg[a] !== 8'(k - 1)) begin
               failures++; $display("FAIL stream_out k=%0d got=%b/%h exp=%b/%h", k, ov, omsg[a], exp_ov, 8'(k - 1));
            end
         end
         tick();
      end
      ival = 1'b0;
      #1;
      checks++; if (ov !== 3'b100 || omsg[2] !== 8'h0B) begin failures++; $display("FAIL stream_last got=%b/%h exp=100/0b", ov, omsg[2]); end
      tick();
      checks++; if (ov !== 3'b000) begin failures++; $display("FAIL stream_drained got=%b exp=000", ov); end
   endtask

   task automatic test_reset_mid();
      set_rdy(3'b000);
      ival = 1'b1; imsg = {2'd0, 8'h01};
      tick();
      imsg = {2'd1, 8'h02};
      tick();
      ival = 1'b0;
      #1;
      checks++; if (ov !== 3'b001) begin failures++; $display("FAIL mid_pre got=%b exp=001", ov); end
      reset_n = 1'b0;
      #1;
      checks++; if (ov !== 3'b000) begin failures++; $display("FAIL mid_oval got=%b exp=000", ov); end
      checks++; if (irdy !== 1'b0) begin failures++; $display("FAIL mid_irdy got=%b exp=0", irdy); end
      checks++; if (drop !== 16'd0) begin failures++; $display("FAIL mid_drop got=%0d exp=0", drop); end
      #1 reset_n = 1'b1;
      set_rdy(3'b111);
      for (int unsigned c = 0; c < 4; c++) begin
         tick();
         checks++; if (ov !== 3'b000) begin failures++; $display("FAIL mid_stale c=%0d got=%b exp=000", c, ov); end
      end
      ival = 1'b1; imsg = {2'd2, 8'h55};
      tick();
      ival = 1'b0;
      #1;
      checks++; if (ov !== 3'b100 || omsg[2] !== 8'h55) begin failures++; $display("FAIL mid_new got=%b/%h exp=100/55", ov, omsg[2]); end
      tick();
   endtask

   task automatic test_drop_sat();
      set_rdy(3'b111);
      ival = 1'b1; imsg = {2'd3, 8'h00};
      for (int unsigned n = 0; n < 65535; n++) tick();
      checks++; if (drop !== 16'hFFFE) begin failures++; $display("FAIL sat_near got=%h exp=fffe", drop); end
      checks++; if (irdy !== 1'b1) begin failures++; $display("FAIL sat_irdy got=%b exp=1", irdy); end
      tick();
      checks++; if (drop !== 16'hFFFF) begin failures++; $display("FAIL sat_reach got=%h exp=ffff", drop); end
      for (int unsigned n = 0; n < 3; n++) tick();
      checks++; if (drop !== 16'hFFFF) begin failures++; $display("FAIL sat_hold got=%h exp=ffff", drop); end
      ival = 1'b0;
      tick();
   endtask

   initial begin
      test_reset();
      test_single();
      test_full();
      test_invalid();
      test_stream();
      test_reset_mid();
      test_drop_sat();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
